// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial parity path
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY
   } state_t;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_tx.sv
// rtl/serial_parity_tx.sv - LSB-first word serialiser with a trailing parity bit
module serial_parity_tx
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter bit          PARITY_ODD = PAR_EVEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              frame_start,
   output logic              frame_end,
   output logic              busy
);

   localparam int unsigned      CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] w_shreg_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_acc;
   logic              w_acc_nxt;
   logic              w_accept;

   logic              r_ser_out;
   logic              r_ser_valid;
   logic              r_frame_start;
   logic              r_frame_end;
   logic              r_busy;
   logic              w_ser_out_nxt;
   logic              w_frame_start_nxt;
   logic              w_frame_end_nxt;

   // The parity cycle also accepts, so frames can run back to back.
   assign in_ready = !rst && (r_state != DATA);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = DATA;
               w_shreg_nxt = in_data;
               w_cnt_nxt   = '0;
               w_acc_nxt   = 1'b0;
            end
         end
         DATA: begin
            w_shreg_nxt = r_shreg >> 1;
            w_acc_nxt   = r_acc ^ r_shreg[0];
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_state_nxt = PARITY;
               w_cnt_nxt   = '0;
            end
         end
         PARITY: begin
            if (w_accept) begin
               w_state_nxt = DATA;
               w_shreg_nxt = in_data;
               w_cnt_nxt   = '0;
               w_acc_nxt   = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they come straight from flops.
   always_comb begin
      w_ser_out_nxt     = 1'b0;
      w_frame_start_nxt = 1'b0;
      w_frame_end_nxt   = 1'b0;
      if (w_state_nxt == DATA) begin
         w_ser_out_nxt     = w_shreg_nxt[0];
         w_frame_start_nxt = (w_cnt_nxt == '0);
      end else if (w_state_nxt == PARITY) begin
         w_ser_out_nxt   = w_acc_nxt ^ PARITY_ODD;
         w_frame_end_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_shreg       <= '0;
         r_cnt         <= '0;
         r_acc         <= 1'b0;
         r_ser_out     <= 1'b0;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_shreg       <= w_shreg_nxt;
         r_cnt         <= w_cnt_nxt;
         r_acc         <= w_acc_nxt;
         r_ser_out     <= w_ser_out_nxt;
         r_ser_valid   <= (w_state_nxt != IDLE);
         r_frame_start <= w_frame_start_nxt;
         r_frame_end   <= w_frame_end_nxt;
         r_busy        <= (w_state_nxt != IDLE);
      end
   end

   assign ser_out     = r_ser_out;
   assign ser_valid   = r_ser_valid;
   assign frame_start = r_frame_start;
   assign frame_end   = r_frame_end;
   assign busy        = r_busy;

endmodule

// File: tb/tb_serial_parity_tx.sv
// tb/tb_serial_parity_tx.sv - vector table and scoreboard bench for serial_parity_tx
module tb_serial_parity_tx;
   import serial_pkg::*;

   typedef struct packed {
      logic so;
      logic fs;
      logic fe;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      bit         odd;
      logic       par;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] e_in_data, o_in_data;
   logic       e_in_valid, o_in_valid;
   logic       e_in_ready, e_ser_out, e_ser_valid, e_frame_start, e_frame_end, e_busy;
   logic       o_in_ready, o_ser_out, o_ser_valid, o_frame_start, o_frame_end, o_busy;

   int         checks = 0;
   int         errors = 0;
   exp_t       q_even[$];
   exp_t       q_odd[$];
   logic       z_even = 1'b0;
   logic       z_odd  = 1'b0;
   vec_t       vecs[8];

   always #5 clk = ~clk;

   serial_parity_tx #(.DATA_W(8), .PARITY_ODD(PAR_EVEN)) dut_even (
      .clk(clk), .rst(rst), .in_data(e_in_data), .in_valid(e_in_valid),
      .in_ready(e_in_ready), .ser_out(e_ser_out), .ser_valid(e_ser_valid),
      .frame_start(e_frame_start), .frame_end(e_frame_end), .busy(e_busy)
   );

   serial_parity_tx #(.DATA_W(8), .PARITY_ODD(PAR_ODD)) dut_odd (
      .clk(clk), .rst(rst), .in_data(o_in_data), .in_valid(o_in_valid),
      .in_ready(o_in_ready), .ser_out(o_ser_out), .ser_valid(o_ser_valid),
      .frame_start(o_frame_start), .frame_end(o_frame_end), .busy(o_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic ready_of(input bit odd);
      return odd ? o_in_ready : e_in_ready;
   endfunction

   task automatic drive(input bit odd, input logic v, input logic [7:0] d);
      if (odd) begin
         o_in_valid = v;
         o_in_data  = d;
      end else begin
         e_in_valid = v;
         e_in_data  = d;
      end
   endtask

   task automatic push_frame(input bit odd, input logic [7:0] d, input logic par);
      exp_t x;
      for (int i = 0; i < 9; i++) begin
         x.so = (i < 8) ? d[i] : par;
         x.fs = (i == 0);
         x.fe = (i == 8);
         if (odd) q_odd.push_back(x);
         else     q_even.push_back(x);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input bit odd, input logic [7:0] d, input logic par);
      int n;
      n = 0;
      drive(odd, 1'b1, d);
      while (!ready_of(odd) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_accept expected=accept");
      end else begin
         push_frame(odd, d, par);
         @(negedge clk);
         chk("first_bit_start", odd ? o_frame_start : e_frame_start, 32'd1);
      end
   endtask

   task automatic wait_idle(input bit odd);
      int n;
      n = 0;
      while ((odd ? (q_odd.size() != 0 || o_busy) : (q_even.size() != 0 || e_busy)) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=busy expected=idle");
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         if (e_ser_valid) begin
            if (q_even.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL even_unexpected_bit actual=ser_valid expected=no_frame");
            end else begin
               x = q_even.pop_front();
               chk("even_ser_out", e_ser_out, x.so);
               chk("even_frame_start", e_frame_start, x.fs);
               chk("even_frame_end", e_frame_end, x.fe);
            end
            z_even = e_frame_start ? e_ser_out : (z_even ^ e_ser_out);
            if (e_frame_end) chk("even_detector_z", z_even, PAR_EVEN);
         end else begin
            chk("even_idle_ser_out", e_ser_out, 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         if (o_ser_valid) begin
            if (q_odd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL odd_unexpected_bit actual=ser_valid expected=no_frame");
            end else begin
               x = q_odd.pop_front();
               chk("odd_ser_out", o_ser_out, x.so);
               chk("odd_frame_start", o_frame_start, x.fs);
               chk("odd_frame_end", o_frame_end, x.fe);
            end
            z_odd = o_frame_start ? o_ser_out : (z_odd ^ o_ser_out);
            if (o_frame_end) chk("odd_detector_z", z_odd, PAR_ODD);
         end else begin
            chk("odd_idle_ser_out", o_ser_out, 32'd0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, odd: 1'b0, par: 1'b0};
      vecs[1] = '{data: 8'h07, odd: 1'b0, par: 1'b1};
      vecs[2] = '{data: 8'h00, odd: 1'b1, par: 1'b1};
      vecs[3] = '{data: 8'hFF, odd: 1'b1, par: 1'b1};
      vecs[4] = '{data: 8'h00, odd: 1'b0, par: 1'b0};
      vecs[5] = '{data: 8'hFF, odd: 1'b0, par: 1'b0};
      vecs[6] = '{data: 8'h3C, odd: 1'b0, par: 1'b0};
      vecs[7] = '{data: 8'h01, odd: 1'b1, par: 1'b0};

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      chk("rst_ser_out", e_ser_out, 32'd0);
      chk("rst_ser_valid", e_ser_valid, 32'd0);
      chk("rst_frame_start", e_frame_start, 32'd0);
      chk("rst_frame_end", e_frame_end, 32'd0);
      chk("rst_busy", e_busy, 32'd0);
      chk("rst_in_ready", e_in_ready, 32'd0);
      chk("rst_odd_in_ready", o_in_ready, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", e_in_ready, 32'd1);
      chk("post_rst_odd_ready", o_in_ready, 32'd1);

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].odd, vecs[i].data, vecs[i].par);
         drive(vecs[i].odd, 1'b0, 8'h00);
         wait_idle(vecs[i].odd);
      end

      // Back-to-back frames with in_valid held high across the boundary.
      chk("b2b_ready_idle", e_in_ready, 32'd1);
      drive(1'b0, 1'b1, 8'hA5);
      push_frame(1'b0, 8'hA5, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h07);
      push_frame(1'b0, 8'h07, 1'b1);
      for (int c = 1; c <= 18; c++) begin
         chk("b2b_valid", e_ser_valid, 32'd1);
         chk("b2b_ready", e_in_ready, 32'((c == 9) || (c == 18)));
         chk("b2b_start", e_frame_start, 32'((c == 1) || (c == 10)));
         if (c == 10) drive(1'b0, 1'b0, 8'h00);
         @(negedge clk);
      end
      wait_idle(1'b0);

      // Reset during data bit 4 aborts the frame; valid during reset is ignored.
      send(1'b0, 8'h3C, 1'b0);
      drive(1'b0, 1'b0, 8'h00);
      repeat (4) @(negedge clk);
      chk("abort_bit4", e_ser_out, 32'd1);
      rst = 1'b1;
      drive(1'b0, 1'b1, 8'h3C);
      @(negedge clk);
      chk("abort_ser_valid", e_ser_valid, 32'd0);
      chk("abort_busy", e_busy, 32'd0);
      chk("abort_frame_end", e_frame_end, 32'd0);
      chk("abort_ready_in_rst", e_in_ready, 32'd0);
      q_even.delete();
      q_odd.delete();
      @(negedge clk);
      chk("rst_valid_ignored", e_busy, 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("abort_no_frame_end", e_frame_end, 32'd0);
         chk("abort_no_valid", e_ser_valid, 32'd0);
      end
      send(1'b0, 8'h3C, 1'b0);
      drive(1'b0, 1'b0, 8'h00);
      wait_idle(1'b0);

      // Stall with in_valid low, then a fresh frame.
      repeat (5) begin
         chk("stall_valid", e_ser_valid, 32'd0);
         chk("stall_ser_out", e_ser_out, 32'd0);
         chk("stall_ready", e_in_ready, 32'd1);
         @(negedge clk);
      end
      send(1'b0, 8'h5A, 1'b0);
      drive(1'b0, 1'b0, 8'h00);
      wait_idle(1'b0);
      send(1'b1, 8'h5A, 1'b1);
      drive(1'b1, 1'b0, 8'h00);
      wait_idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
